// File: rtl/arith_pkg.sv
// Shared constants for arithmetic blocks built on the 4-bit ripple adder:
// datapath width, iteration count and the multiplier FSM state encoding.
package arith_pkg;

  localparam int WIDTH      = 4;
  localparam int ITERATIONS = 4;

  typedef logic [1:0] state_t;

  // 2'b11 is unused and steers back to IDLE.
  localparam state_t ST_IDLE = 2'b00;
  localparam state_t ST_RUN  = 2'b01;
  localparam state_t ST_DONE = 2'b10;

  function automatic logic is_last_iter(input logic [1:0] cnt);
    return cnt == 2'(ITERATIONS - 1);
  endfunction

endpackage

// File: rtl/shift_add_multiplier_adder.sv
// Four-bit ripple-carry adder: a chain of full adders with carry-in and
// carry-out, used as the shared add datapath.
module shift_add_multiplier_adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
      assign s[gi]         = x[gi] ^ y[gi] ^ carry[gi];
      assign carry[gi + 1] = (x[gi] & y[gi]) | (carry[gi] & (x[gi] ^ y[gi]));
    end
  endgenerate

  assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one add-and-shift per cycle
// over four cycles, producing a 2*WIDTH product with a one-cycle done pulse.
module shift_add_multiplier
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   m_q, m_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   add_y;
  logic [WIDTH-1:0]   add_s;
  logic               add_co;
  logic [2*WIDTH-1:0] shifted;

  assign add_y = q_q[0] ? m_q : '0;

  shift_add_multiplier_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .x    (acc_q),
    .y    (add_y),
    .cin  (1'b0),
    .s    (add_s),
    .cout (add_co)
  );

  // Carry lands in the top bit of A after the shift, so nothing is lost.
  assign shifted = {add_co, add_s, q_q[WIDTH-1:1]};

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      // The edge leaving DONE also samples start, giving one result per five cycles.
      ST_IDLE, ST_DONE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        {acc_d, q_d} = shifted;
        cnt_d        = cnt_q + 2'd1;
        if (is_last_iter(cnt_q)) begin
          product_d = shifted;
          state_d   = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: reset, basic products, start while
// busy, mid-operation reset, back-to-back issue and an exhaustive sweep.
module tb_shift_add_multiplier;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  shift_add_multiplier #(
    .WIDTH (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, observed, expected);
    end
  endtask

  // Issue one operation, then verify latency, product, pulse width and exclusivity.
  task automatic run_op(input logic [3:0] av, input logic [3:0] bv, input logic [7:0] exp, input string tag);
    int n;
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a     = 4'($urandom);
    b     = 4'($urandom);
    check({tag, "_busy_acc"}, 8'(busy), 8'h01);
    n = 0;
    while (!done && n < 8) begin
      @(negedge clk);
      n++;
      check({tag, "_excl"}, 8'(busy & done), 8'h00);
    end
    check({tag, "_latency"}, 8'(n), 8'd4);
    check({tag, "_product"}, product, exp);
    check({tag, "_busy_done"}, 8'(busy), 8'h00);
    @(negedge clk);
    check({tag, "_pulse"}, 8'(done), 8'h00);
    $display("[TB] op %s a=0x%h b=0x%h product=0x%02h latency=%0d", tag, av, bv, exp, n);
  endtask

  initial begin
    int done_cnt;
    int d1;
    int d2;

    rst   = 1'b1;
    start = 1'b0;
    a     = 4'h0;
    b     = 4'h0;

    // Reset then idle
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 8'(busy), 8'h00);
    check("rst_done", 8'(done), 8'h00);
    check("rst_product", product, 8'h00);
    repeat (10) @(negedge clk);
    check("idle_busy", 8'(busy), 8'h00);
    check("idle_done", 8'(done), 8'h00);
    check("idle_product", product, 8'h00);

    // Basic products
    run_op(4'h5, 4'h3, 8'h0F, "p5x3");
    run_op(4'h9, 4'hA, 8'h5A, "p9xA");
    run_op(4'hF, 4'hF, 8'hE1, "pFxF");
    run_op(4'h0, 4'hB, 8'h00, "p0xB");

    // Start pulses while busy are ignored
    @(negedge clk);
    start = 1'b1; a = 4'h2; b = 4'h3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("sdb_product_held", product, 8'h00);
    @(negedge clk);
    start = 1'b1; a = 4'hF; b = 4'hF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("sdb_done", 8'(done), 8'h01);
    check("sdb_product", product, 8'h06);
    done_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) done_cnt++;
      check("sdb_no_rerun", 8'(busy), 8'h00);
    end
    check("sdb_extra_done", 8'(done_cnt), 8'h00);
    $display("[TB] op start_during_busy product=0x%02h", product);

    // Reset mid-operation
    @(negedge clk);
    start = 1'b1; a = 4'h7; b = 4'h7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_busy", 8'(busy), 8'h00);
    check("mrst_done", 8'(done), 8'h00);
    check("mrst_product", product, 8'h00);
    done_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("mrst_no_done", 8'(done_cnt), 8'h00);
    $display("[TB] op reset_mid_run busy=%0d product=0x%02h", busy, product);

    // Back-to-back with start held high
    @(negedge clk);
    start = 1'b1; a = 4'h3; b = 4'h4;
    d1 = 0;
    d2 = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) break;
    end
    check("b2b_done1", 8'(done), 8'h01);
    check("b2b_product1", product, 8'h0C);
    d1 = cyc;
    a = 4'h6; b = 4'h2;
    @(negedge clk);
    check("b2b_reaccept", 8'(busy), 8'h01);
    repeat (8) begin
      @(negedge clk);
      if (done) break;
    end
    start = 1'b0;
    check("b2b_done2", 8'(done), 8'h01);
    check("b2b_product2", product, 8'h0C);
    d2 = cyc;
    check("b2b_spacing", 8'(d2 - d1), 8'd5);
    $display("[TB] op back_to_back spacing=%0d product=0x%02h", d2 - d1, product);
    repeat (6) @(negedge clk);

    // Exhaustive sweep
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run_op(4'(i), 4'(j), 8'(i * j), $sformatf("ex%0hx%0h", i, j));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
